// File: rtl/mips_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, core redirect,
// and the decode-side instruction handshake plus fetch status.
interface mips_fetch_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          imem_req_valid;
  logic [31:0]   imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    output fetch_pc, inflight
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    input  fetch_pc, inflight
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, prefetch FIFO of
// {word, pc}, and redirect handling that drops stale in-flight responses.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  mips_fetch_if.master   bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;

  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic          has_credit;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_drop;
  logic          fifo_empty;
  logic          inst_valid;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_aligned;

  // Every slot is reserved at request time, so a response always has room.
  assign credit_used = {1'b0, inflight_reg} + {1'b0, count_reg};
  assign has_credit  = credit_used < (CW+1)'(FIFO_DEPTH);
  assign req_valid   = has_credit && !bus.redirect_valid && !reset;
  assign req_fire    = req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_live    = bus.imem_rsp_valid && (inflight_reg != '0);
  assign rsp_drop    = (discard_reg != '0);

  assign fifo_empty  = (count_reg == '0);
  assign inst_valid  = !fifo_empty && !bus.redirect_valid;
  assign pop         = inst_valid && bus.inst_ready;
  assign push        = rsp_live && !rsp_drop && !bus.redirect_valid;

  assign redirect_aligned = bus.redirect_pc & ~32'h0000_0003;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rsp_pc_next   = rsp_pc_reg;
    discard_next  = discard_reg;
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_live);

    if (bus.redirect_valid) begin
      fetch_pc_next = redirect_aligned;
      rsp_pc_next   = redirect_aligned;
      // Everything still outstanding belongs to the old path.
      discard_next  = inflight_reg - CW'(rsp_live);
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (rsp_live && rsp_drop) begin
        discard_next = discard_reg - CW'(1);
      end
      if (push) begin
        rsp_pc_next = rsp_pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      discard_reg  <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rsp_pc_reg   <= rsp_pc_next;
      inflight_reg <= inflight_next;
      discard_reg  <= discard_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= bus.imem_rsp_data;
      pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_reg;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_data      = fifo_empty ? 32'h0 : data_mem[rd_ptr_reg];
  assign bus.inst_pc        = fifo_empty ? 32'h0 : pc_mem[rd_ptr_reg];
  assign bus.fetch_pc       = fetch_pc_reg;
  assign bus.inflight       = inflight_reg;
endmodule
